// File: rtl/cordic_rotate_iter.sv
// Iterative rotation-mode CORDIC: rotates (x,y) by a 16-bit binary angle, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a one-cycle COMP state that cancels the CORDIC gain.
module cordic_rotate_iter #(
  parameter int W     = 16,
  parameter int ITERS = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic [15:0]         angle_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W+1:0] x_out,
  output logic signed [W+1:0] y_out
);

  localparam int XW = W + 2;

  // Handshake: a transfer happens on a clock edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and the result is held until out_ready.
  typedef enum logic [1:0] {S_IDLE, S_ROT, S_COMP, S_DONE} state_t;

  state_t state, state_nxt;

  logic signed [XW-1:0] x_q, y_q, x_nxt, y_nxt;
  logic signed [XW-1:0] x_res, y_res;
  logic signed [XW-1:0] xs, ys, x_sh, y_sh;
  logic signed [15:0]   z_q, z_nxt;
  logic [4:0]           i_q, i_nxt;
  logic [1:0]           q;
  logic                 load_out;

  function automatic logic signed [15:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 16'sd8192;
      5'd1:    atan_lut = 16'sd4836;
      5'd2:    atan_lut = 16'sd2555;
      5'd3:    atan_lut = 16'sd1297;
      5'd4:    atan_lut = 16'sd651;
      5'd5:    atan_lut = 16'sd326;
      5'd6:    atan_lut = 16'sd163;
      5'd7:    atan_lut = 16'sd81;
      5'd8:    atan_lut = 16'sd41;
      5'd9:    atan_lut = 16'sd20;
      5'd10:   atan_lut = 16'sd10;
      5'd11:   atan_lut = 16'sd5;
      5'd12:   atan_lut = 16'sd3;
      5'd13:   atan_lut = 16'sd1;
      5'd14:   atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  assign xs = {{2{x_in[W-1]}}, x_in};
  assign ys = {{2{y_in[W-1]}}, y_in};
  // Quadrant of angle rounded to the nearest multiple of 90 deg: adding 0x2000 carries out of bit 13.
  assign q    = angle_in[15:14] + {1'b0, angle_in[13]};
  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;

  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    z_nxt     = z_q;
    i_nxt     = i_q;
    load_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          case (q)
            2'd0:    begin x_nxt = xs;  y_nxt = ys;  end
            2'd1:    begin x_nxt = -ys; y_nxt = xs;  end
            2'd2:    begin x_nxt = -xs; y_nxt = -ys; end
            default: begin x_nxt = ys;  y_nxt = -xs; end
          endcase
          z_nxt     = $signed(angle_in - {q, 14'd0});
          i_nxt     = 5'd0;
          state_nxt = S_ROT;
        end
      end
      S_ROT: begin
        if (!z_q[15]) begin
          x_nxt = x_q - y_sh;
          y_nxt = y_q + x_sh;
          z_nxt = z_q - atan_lut(i_q);
        end else begin
          x_nxt = x_q + y_sh;
          y_nxt = y_q - x_sh;
          z_nxt = z_q + atan_lut(i_q);
        end
        i_nxt = i_q + 5'd1;
        if (i_q == 5'(ITERS - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nxt = S_COMP;
`else
          state_nxt = S_DONE;
          load_out  = 1'b1;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_COMP: begin
        // 1/2 + 1/8 - 1/64 - 1/512 = 0.6074, close to 1/K
        x_nxt     = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
        y_nxt     = (y_q >>> 1) + (y_q >>> 3) - (y_q >>> 6) - (y_q >>> 9);
        state_nxt = S_DONE;
        load_out  = 1'b1;
      end
`endif
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      i_q   <= '0;
      x_res <= '0;
      y_res <= '0;
    end else begin
      state <= state_nxt;
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      z_q   <= z_nxt;
      i_q   <= i_nxt;
      if (load_out) begin
        x_res <= x_nxt;
        y_res <= y_nxt;
      end
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign x_out     = x_res;
  assign y_out     = y_res;

endmodule

// File: tb/tb_cordic_rotate_iter.sv
// Self-checking bench for cordic_rotate_iter: directed and random vectors against a floating-point rotation model.
module tb_cordic_rotate_iter;

  localparam int W     = 16;
  localparam int ITERS = 14;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  COMP = 1;
  localparam real CFAC = 0.607421875;
`else
  localparam int  COMP = 0;
  localparam real CFAC = 1.0;
`endif
  localparam int  LAT = ITERS + 1 + COMP;
  localparam real PI  = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic [15:0]         angle_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W+1:0] x_out;
  logic signed [W+1:0] y_out;

  cordic_rotate_iter #(.W(W), .ITERS(ITERS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic signed [W+1:0] exp_x_q[$];
  logic signed [W+1:0] exp_y_q[$];
  int                  tol_x_q[$];
  int                  tol_y_q[$];

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    n_checks++;
    if (obs - exp > tol || exp - obs > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

  // Ideal rotation by angle*2pi/65536 scaled by the CORDIC gain (and compensation when built in).
  task automatic push_exp(input int x, input int y, input int a, input int tx, input int ty);
    real k, th, ex, ey, mag;
    k = 1.0;
    for (int i = 0; i < ITERS; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    k   = k * CFAC;
    th  = a * 2.0 * PI / 65536.0;
    ex  = k * (x * $cos(th) - y * $sin(th));
    ey  = k * (x * $sin(th) + y * $cos(th));
    mag = $sqrt(ex * ex + ey * ey);
    exp_x_q.push_back((W+2)'(rnd(ex)));
    exp_y_q.push_back((W+2)'(rnd(ey)));
    tol_x_q.push_back((tx < 0) ? 16 + rnd(mag / 2000.0) : tx);
    tol_y_q.push_back((ty < 0) ? 16 + rnd(mag / 2000.0) : ty);
  endtask

  task automatic drive_in(input int x, input int y, input int a, input int tx, input int ty);
    x_in     = W'(x);
    y_in     = W'(y);
    angle_in = 16'(a);
    in_valid = 1'b1;
    push_exp(x, y, a, tx, ty);
  endtask

  task automatic wait_accept(output int edges);
    logic r;
    logic got;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 100) begin
      r = in_ready;
      @(posedge clk); #1;
      edges++;
      if (r) got = 1'b1;
    end
    in_valid = 1'b0;
    chk("accept", int'(got), 1, 0);
  endtask

  task automatic wait_result(input int hold);
    int lat;
    int ex, ey, tx, ty;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, LAT, 0);
    ex = int'(exp_x_q.pop_front());
    ey = int'(exp_y_q.pop_front());
    tx = tol_x_q.pop_front();
    ty = tol_y_q.pop_front();
    chk("x_out", int'(x_out), ex, tx);
    chk("y_out", int'(y_out), ey, ty);
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_valid", int'(out_valid), 1, 0);
        chk("hold_ready", int'(in_ready), 0, 0);
        chk("hold_x", int'(x_out), ex, tx);
        chk("hold_y", int'(y_out), ey, ty);
      end
      out_ready = 1'b1;
    end
  endtask

  int dx[6] = '{10000, 10000, 10000, 0,     10000, -32768};
  int dy[6] = '{0,     0,     0,     10000, 0,     -32768};
  int da[6] = '{16'h4000, 16'h2000, 16'h8000, 16'hE000, 16'h0000, 16'h6000};
`ifdef CORDIC_GAIN_COMP_EN
  int dtx[6] = '{8,  12, 12, 12, -1, -1};
  int dty[6] = '{12, 12, 12, 12, -1, -1};
`else
  int dtx[6] = '{-1, -1, -1, -1, 10, -1};
  int dty[6] = '{-1, -1, -1, -1, 8,  -1};
`endif

  initial begin
    int edges;
    logic signed [15:0] rx, ry;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;
    angle_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_x_out", int'(x_out), 0, 0);
    chk("rst_y_out", int'(y_out), 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", int'(in_ready), 1, 0);

    // Directed vectors; the first holds off the consumer, later ones are offered while DONE is draining.
    for (int k = 0; k < 6; k++) begin
      drive_in(dx[k], dy[k], da[k], dtx[k], dty[k]);
      wait_accept(edges);
      if (k > 0) chk("no_bypass_edges", edges, 2, 0);
      else chk("first_accept_edges", edges, 1, 0);
      wait_result((k == 0) ? 5 : 0);
    end
    @(posedge clk); #1;

    // Reset during the fifth ROT cycle discards the partial result.
    drive_in(12345, -2222, 16'h3456, -1, -1);
    wait_accept(edges);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(exp_x_q.pop_back());
    void'(exp_y_q.pop_back());
    void'(tol_x_q.pop_back());
    void'(tol_y_q.pop_back());
    chk("mid_rst_in_ready", int'(in_ready), 1, 0);
    chk("mid_rst_out_valid", int'(out_valid), 0, 0);
    chk("mid_rst_x_out", int'(x_out), 0, 0);
    chk("mid_rst_y_out", int'(y_out), 0, 0);
    repeat (ITERS + 3) begin @(posedge clk); #1; end
    chk("mid_rst_no_stale_valid", int'(out_valid), 0, 0);
    drive_in(10000, 0, 16'h2000, -1, -1);
    wait_accept(edges);
    chk("post_rst_accept_edges", edges, 1, 0);
    wait_result(0);

    // Back-to-back random transactions with the consumer always ready.
    for (int k = 0; k < 8; k++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = 16'($urandom_range(0, 65535));
      drive_in(int'(rx), int'(ry), int'($urandom_range(0, 65535)), -1, -1);
      wait_accept(edges);
      wait_result(0);
    end
    @(posedge clk); #1;
    chk("final_in_ready", int'(in_ready), 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
